// File: rtl/id_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_decode_stage
// Description : Instruction-decode stage. Holds the IF/ID latch, the register
//               file with same-cycle WB bypass and load-use hazard detection,
//               and produces the ID/EX register inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module id_decode_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic            flush,
    input  logic            id_ex_memread,
    input  logic [4:0]      id_ex_register_rd,
    input  logic            wb_regwrite,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic [4:0]      if_id_register_rs1,
    output logic [4:0]      if_id_register_rs2,
    output logic [4:0]      if_id_register_rd,
    output logic [XLEN-1:0] if_id_output_data_1,
    output logic [XLEN-1:0] if_id_output_data_2,
    output logic [XLEN-1:0] if_id_sign_extend_immediate,
    output logic [9:0]      control,
    output logic            illegal
);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;

    // Upper control bits: regwrite, memtoreg, memread, memwrite, branch, alusrc
    localparam logic [5:0] c_CW_R      = 6'b100000;
    localparam logic [5:0] c_CW_I_ALU  = 6'b100001;
    localparam logic [5:0] c_CW_LOAD   = 6'b111001;
    localparam logic [5:0] c_CW_STORE  = 6'b000101;
    localparam logic [5:0] c_CW_BRANCH = 6'b000010;

    logic [31:0]     r_instr;
    logic            r_valid;
    logic [XLEN-1:0] r_regs [NREG];

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_funct7b5;
    logic [9:0]      w_dec_ctrl;
    logic            w_supported;
    logic            w_uses_rs2;
    logic [XLEN-1:0] w_imm;
    logic            w_wb_en;
    logic            w_hazard_rs1;
    logic            w_hazard_rs2;

    // ------------------------------------------------------------------------
    // IF/ID latch: flush beats stall; instruction bits are kept on flush
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (!stall) begin
            r_instr <= if_instr;
            r_valid <= if_valid;
        end
    end

    assign w_opcode   = r_instr[6:0];
    assign w_funct3   = r_instr[14:12];
    assign w_funct7b5 = r_instr[30];

    assign if_id_register_rs1 = r_instr[19:15];
    assign if_id_register_rs2 = r_instr[24:20];
    assign if_id_register_rd  = r_instr[11:7];

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_dec_ctrl  = '0;
        w_supported = 1'b0;
        w_uses_rs2  = 1'b0;
        w_imm       = '0;
        case (w_opcode)
            c_OP_R: begin
                w_uses_rs2 = 1'b1;
                case (w_funct3)
                    3'b000: begin
                        w_supported = 1'b1;
                        w_dec_ctrl  = {c_CW_R, (w_funct7b5 ? c_ALU_SUB : c_ALU_ADD)};
                    end
                    3'b111: begin
                        w_supported = 1'b1;
                        w_dec_ctrl  = {c_CW_R, c_ALU_AND};
                    end
                    3'b110: begin
                        w_supported = 1'b1;
                        w_dec_ctrl  = {c_CW_R, c_ALU_OR};
                    end
                    default: w_supported = 1'b0;
                endcase
            end
            c_OP_I_ALU: begin
                w_imm = {{(XLEN-12){r_instr[31]}}, r_instr[31:20]};
                case (w_funct3)
                    3'b000: begin
                        w_supported = 1'b1;
                        w_dec_ctrl  = {c_CW_I_ALU, c_ALU_ADD};
                    end
                    3'b111: begin
                        w_supported = 1'b1;
                        w_dec_ctrl  = {c_CW_I_ALU, c_ALU_AND};
                    end
                    3'b110: begin
                        w_supported = 1'b1;
                        w_dec_ctrl  = {c_CW_I_ALU, c_ALU_OR};
                    end
                    default: w_supported = 1'b0;
                endcase
            end
            c_OP_LOAD: begin
                w_imm = {{(XLEN-12){r_instr[31]}}, r_instr[31:20]};
                if (w_funct3 == 3'b010) begin
                    w_supported = 1'b1;
                    w_dec_ctrl  = {c_CW_LOAD, c_ALU_ADD};
                end
            end
            c_OP_STORE: begin
                w_uses_rs2 = 1'b1;
                w_imm      = {{(XLEN-12){r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
                if (w_funct3 == 3'b010) begin
                    w_supported = 1'b1;
                    w_dec_ctrl  = {c_CW_STORE, c_ALU_ADD};
                end
            end
            c_OP_BRANCH: begin
                w_uses_rs2 = 1'b1;
                w_imm      = {{(XLEN-13){r_instr[31]}}, r_instr[31], r_instr[7],
                              r_instr[30:25], r_instr[11:8], 1'b0};
                if (w_funct3 == 3'b000) begin
                    w_supported = 1'b1;
                    w_dec_ctrl  = {c_CW_BRANCH, c_ALU_SUB};
                end
            end
            default: w_supported = 1'b0;
        endcase
    end

    assign if_id_sign_extend_immediate = w_imm;

    // ------------------------------------------------------------------------
    // Load-use hazard and bubble insertion
    // ------------------------------------------------------------------------
    assign w_hazard_rs1 = (id_ex_register_rd == if_id_register_rs1);
    assign w_hazard_rs2 = (id_ex_register_rd == if_id_register_rs2) & w_uses_rs2;

    assign stall   = r_valid & id_ex_memread & (id_ex_register_rd != 5'd0)
                   & (w_hazard_rs1 | w_hazard_rs2);
    assign illegal = r_valid & ~w_supported;
    assign control = (r_valid & w_supported & ~stall) ? w_dec_ctrl : 10'd0;

    // ------------------------------------------------------------------------
    // Register file: x0 is never written and always reads zero
    // ------------------------------------------------------------------------
    assign w_wb_en = wb_regwrite & (wb_rd != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_en) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        if (if_id_register_rs1 == 5'd0) begin
            if_id_output_data_1 = '0;
        end else if (w_wb_en && (wb_rd == if_id_register_rs1)) begin
            if_id_output_data_1 = wb_data;
        end else begin
            if_id_output_data_1 = r_regs[if_id_register_rs1];
        end
    end

    always_comb begin
        if (if_id_register_rs2 == 5'd0) begin
            if_id_output_data_2 = '0;
        end else if (w_wb_en && (wb_rd == if_id_register_rs2)) begin
            if_id_output_data_2 = wb_data;
        end else begin
            if_id_output_data_2 = r_regs[if_id_register_rs2];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_id_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_decode_stage
// Description : Self-checking bench for id_decode_stage: decode vector table,
//               directed pipeline sequences and a randomized model comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        flush;
    logic        id_ex_memread;
    logic [4:0]  id_ex_register_rd;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] data1, data2, imm;
    logic [9:0]  control;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    id_decode_stage #(.XLEN(32), .NREG(32)) dut (
        .clk                         (clk),
        .reset                       (reset),
        .if_valid                    (if_valid),
        .if_instr                    (if_instr),
        .flush                       (flush),
        .id_ex_memread               (id_ex_memread),
        .id_ex_register_rd           (id_ex_register_rd),
        .wb_regwrite                 (wb_regwrite),
        .wb_rd                       (wb_rd),
        .wb_data                     (wb_data),
        .stall                       (stall),
        .if_id_register_rs1          (rs1),
        .if_id_register_rs2          (rs2),
        .if_id_register_rd           (rd),
        .if_id_output_data_1         (data1),
        .if_id_output_data_2         (data2),
        .if_id_sign_extend_immediate (imm),
        .control                     (control),
        .illegal                     (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  ctrl;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    typedef enum int {K_ADD, K_SUB, K_AND, K_OR, K_ADDI, K_ANDI, K_ORI,
                      K_LW, K_SW, K_BEQ, K_BAD} kind_e;

    // Reference model state
    logic [31:0] m_regs [32];
    logic [31:0] m_instr;
    logic        m_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle();
        if_valid = 1'b0; if_instr = 32'h0; flush = 1'b0;
        id_ex_memread = 1'b0; id_ex_register_rd = 5'd0;
        wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = 32'h0;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    function automatic kind_e classify(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        case (ins[6:0])
            7'b0110011: begin
                if (f3 == 3'd0) return ins[30] ? K_SUB : K_ADD;
                if (f3 == 3'd7) return K_AND;
                if (f3 == 3'd6) return K_OR;
                return K_BAD;
            end
            7'b0010011: begin
                if (f3 == 3'd0) return K_ADDI;
                if (f3 == 3'd7) return K_ANDI;
                if (f3 == 3'd6) return K_ORI;
                return K_BAD;
            end
            7'b0000011: return (f3 == 3'd2) ? K_LW : K_BAD;
            7'b0100011: return (f3 == 3'd2) ? K_SW : K_BAD;
            7'b1100011: return (f3 == 3'd0) ? K_BEQ : K_BAD;
            default:    return K_BAD;
        endcase
    endfunction

    function automatic logic [9:0] cw(input bit rw, input bit mtr, input bit mr, input bit mw,
                                      input bit br, input bit as, input logic [3:0] alu);
        return {rw, mtr, mr, mw, br, as, alu};
    endfunction

    function automatic logic [9:0] ctrl_of(input kind_e k);
        case (k)
            K_ADD:  return cw(1, 0, 0, 0, 0, 0, 4'd2);
            K_SUB:  return cw(1, 0, 0, 0, 0, 0, 4'd6);
            K_AND:  return cw(1, 0, 0, 0, 0, 0, 4'd0);
            K_OR:   return cw(1, 0, 0, 0, 0, 0, 4'd1);
            K_ADDI: return cw(1, 0, 0, 0, 0, 1, 4'd2);
            K_ANDI: return cw(1, 0, 0, 0, 0, 1, 4'd0);
            K_ORI:  return cw(1, 0, 0, 0, 0, 1, 4'd1);
            K_LW:   return cw(1, 1, 1, 0, 0, 1, 4'd2);
            K_SW:   return cw(0, 0, 0, 1, 0, 1, 4'd2);
            K_BEQ:  return cw(0, 0, 0, 0, 1, 0, 4'd6);
            default: return 10'd0;
        endcase
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] ins);
        int v;
        case (ins[6:0])
            7'b0010011, 7'b0000011: v = int'($signed(ins[31:20]));
            7'b0100011: v = int'($signed({ins[31:25], ins[11:7]}));
            7'b1100011: v = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
            default:    v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  r1, r2, rdd;
        logic [11:0] i12;
        logic [2:0]  f3;
        r1  = 5'($urandom_range(0, 3));
        r2  = 5'($urandom_range(0, 3));
        rdd = 5'($urandom_range(0, 3));
        i12 = 12'($urandom);
        f3  = 3'($urandom);
        case ($urandom_range(0, 11))
            0:  return {7'b0000000, r2, r1, 3'd0, rdd, 7'b0110011};
            1:  return {7'b0100000, r2, r1, 3'd0, rdd, 7'b0110011};
            2:  return {7'b0000000, r2, r1, 3'd7, rdd, 7'b0110011};
            3:  return {7'b0000000, r2, r1, 3'd6, rdd, 7'b0110011};
            4:  return {1'b0, 1'($urandom), 5'b0, r2, r1, f3, rdd, 7'b0110011};
            5:  return {i12, r1, f3, rdd, 7'b0010011};
            6:  return {i12, r1, 3'd2, rdd, 7'b0000011};
            7:  return {i12[11:5], r2, r1, 3'd2, i12[4:0], 7'b0100011};
            8:  return {i12[11:5], r2, r1, 3'd0, i12[4:0], 7'b1100011};
            9:  return {i12[11:5], r2, r1, f3, i12[4:0], 7'b0000011 | {1'b0, 1'($urandom), 5'b0}};
            10: return $urandom;
            default: return {i12[11:5], r2, r1, f3, rdd, 7'h7F};
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
        if (wb_regwrite && wb_rd == r) return wb_data;
        return m_regs[r];
    endfunction

    vec_t tv [13];

    initial begin
        tv[0]  = '{32'h00318233, 10'h202, 32'h00000000, 1'b0};  // add
        tv[1]  = '{32'h400380B3, 10'h206, 32'h00000000, 1'b0};  // sub
        tv[2]  = '{32'h007372B3, 10'h200, 32'h00000000, 1'b0};  // and
        tv[3]  = '{32'h007362B3, 10'h201, 32'h00000000, 1'b0};  // or
        tv[4]  = '{32'hFFF00093, 10'h212, 32'hFFFFFFFF, 1'b0};  // addi -1
        tv[5]  = '{32'h0F00F113, 10'h210, 32'h000000F0, 1'b0};  // andi
        tv[6]  = '{32'h8000E193, 10'h211, 32'hFFFFF800, 1'b0};  // ori -2048
        tv[7]  = '{32'h0080A283, 10'h392, 32'h00000008, 1'b0};  // lw
        tv[8]  = '{32'hFE20AE23, 10'h052, 32'hFFFFFFFC, 1'b0};  // sw -4
        tv[9]  = '{32'hFE000CE3, 10'h026, 32'hFFFFFFF8, 1'b0};  // beq -8
        tv[10] = '{32'h007342B3, 10'h000, 32'h00000000, 1'b1};  // xor
        tv[11] = '{32'h00008283, 10'h000, 32'h00000000, 1'b1};  // lb
        tv[12] = '{32'h0000007F, 10'h000, 32'h00000000, 1'b1};  // bad opcode

        idle();
        reset = 1'b1;
        #1;
        chk("rst_control", 32'(control), 32'h0);
        chk("rst_stall",   32'(stall),   32'h0);
        chk("rst_illegal", 32'(illegal), 32'h0);
        chk("rst_data1",   data1,        32'h0);
        chk("rst_imm",     imm,          32'h0);
        chk("rst_rs1",     32'(rs1),     32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Decode table
        foreach (tv[i]) begin
            if_instr = tv[i].instr;
            if_valid = 1'b1;
            edge_step();
            #1;
            chk($sformatf("tv%0d_control", i), 32'(control), 32'(tv[i].ctrl));
            chk($sformatf("tv%0d_imm", i),     imm,           tv[i].imm);
            chk($sformatf("tv%0d_illegal", i), 32'(illegal), 32'(tv[i].ill));
        end

        // WB writes x3, then add x4,x3,x3 reads it
        wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 32'hAA;
        if_instr = 32'h00318233;
        edge_step();
        wb_regwrite = 1'b0;
        #1;
        chk("wb_data1",   data1,         32'hAA);
        chk("wb_data2",   data2,         32'hAA);
        chk("wb_control", 32'(control), 32'h202);

        // Same-cycle bypass on sub x1,x7,x0
        if_instr = 32'h400380B3;
        edge_step();
        wb_regwrite = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234;
        #1;
        chk("byp_data1",   data1,         32'h1234);
        chk("byp_data2",   data2,         32'h0);
        chk("byp_control", 32'(control), 32'h206);
        edge_step();
        wb_regwrite = 1'b0;

        // Load-use hazard on add x6,x5,x2
        if_instr = 32'h00228333;
        edge_step();
        id_ex_memread = 1'b1; id_ex_register_rd = 5'd5;
        if_instr = 32'h0000007F;
        #1;
        chk("lu_stall",   32'(stall),   32'h1);
        chk("lu_control", 32'(control), 32'h0);
        edge_step();
        id_ex_memread = 1'b0;
        #1;
        chk("lu_release_stall",   32'(stall),   32'h0);
        chk("lu_release_control", 32'(control), 32'h202);
        chk("lu_release_rd",      32'(rd),      32'd6);

        // Flush of a valid instruction, then illegal opcode
        if_instr = 32'h00318233; flush = 1'b1;
        edge_step();
        flush = 1'b0;
        #1;
        chk("flush_control", 32'(control), 32'h0);
        chk("flush_illegal", 32'(illegal), 32'h0);
        if_instr = 32'h0000007F;
        edge_step();
        #1;
        chk("bad_illegal", 32'(illegal), 32'h1);
        chk("bad_control", 32'(control), 32'h0);

        // Flush coincident with a stall on rs2
        if_instr = 32'h00228333;
        edge_step();
        id_ex_memread = 1'b1; id_ex_register_rd = 5'd2; flush = 1'b1;
        #1;
        chk("fs_stall", 32'(stall), 32'h1);
        edge_step();
        flush = 1'b0;
        #1;
        chk("fs_stall_after",   32'(stall),   32'h0);
        chk("fs_control_after", 32'(control), 32'h0);
        id_ex_memread = 1'b0;

        // Asynchronous reset in the middle of a stall
        if_instr = 32'h00228333; if_valid = 1'b1;
        wb_regwrite = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
        edge_step();
        wb_regwrite = 1'b0;
        id_ex_memread = 1'b1; id_ex_register_rd = 5'd5;
        #1;
        chk("ar_pre_stall", 32'(stall), 32'h1);
        chk("ar_pre_data1", data1,       32'h55);
        reset = 1'b1;
        #1;
        chk("ar_stall",   32'(stall),   32'h0);
        chk("ar_control", 32'(control), 32'h0);
        chk("ar_data1",   data1,        32'h0);
        chk("ar_rs1",     32'(rs1),     32'h0);
        id_ex_memread = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        edge_step();
        #1;
        chk("ar_x5_cleared", data1,        32'h0);
        chk("ar_rs1_after",  32'(rs1),     32'd5);
        chk("ar_ctrl_after", 32'(control), 32'h202);

        // Randomized run against the reference model
        idle();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        foreach (m_regs[i]) m_regs[i] = 32'h0;
        m_instr = 32'h0;
        m_valid = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            kind_e       k;
            logic        e_stall, uses2, legal;
            logic [4:0]  mr1, mr2;
            logic [9:0]  e_ctrl;
            if_instr          = rand_instr();
            if_valid          = 1'($urandom_range(0, 7) != 0);
            flush             = ($urandom_range(0, 9) == 0);
            id_ex_memread     = 1'($urandom);
            id_ex_register_rd = 5'($urandom_range(0, 3));
            wb_regwrite       = 1'($urandom);
            wb_rd             = 5'($urandom_range(0, 3));
            wb_data           = $urandom;
            #1;
            k     = classify(m_instr);
            legal = (k != K_BAD);
            mr1   = m_instr[19:15];
            mr2   = m_instr[24:20];
            uses2 = (m_instr[6:0] == 7'b0110011) || (m_instr[6:0] == 7'b0100011)
                 || (m_instr[6:0] == 7'b1100011);
            e_stall = m_valid && id_ex_memread && (id_ex_register_rd != 5'd0)
                   && ((id_ex_register_rd == mr1) || (uses2 && id_ex_register_rd == mr2));
            e_ctrl  = (m_valid && legal && !e_stall) ? ctrl_of(k) : 10'd0;
            chk("rnd_stall",   32'(stall),   32'(e_stall));
            chk("rnd_control", 32'(control), 32'(e_ctrl));
            chk("rnd_illegal", 32'(illegal), 32'(m_valid && !legal));
            chk("rnd_rs1",     32'(rs1),     32'(mr1));
            chk("rnd_rs2",     32'(rs2),     32'(mr2));
            chk("rnd_rd",      32'(rd),      32'(m_instr[11:7]));
            chk("rnd_data1",   data1,        m_read(mr1));
            chk("rnd_data2",   data2,        m_read(mr2));
            chk("rnd_imm",     imm,          imm_of(m_instr));
            edge_step();
            if (flush) begin
                m_valid = 1'b0;
            end else if (!e_stall) begin
                m_instr = if_instr;
                m_valid = if_valid;
            end
            if (wb_regwrite && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_decode_stage.md
Name: id_decode_stage

Overview:
Instruction-decode stage producing every input of the ID/EX pipeline register: register indices, register-file read data, sign-extended immediate and the 10-bit control word. Contains the IF/ID latch, a 32x32 register file with WB write port and same-cycle bypass, and load-use hazard detection. Drives stall back to IF and inserts bubbles when a hazard or flush occurs.

Parameters:
XLEN, 32, datapath width
NREG, 32, register count (x0 hardwired zero)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
if_valid  in  1  IF presents a valid instruction
if_instr  in  32  instruction from IF
flush  in  1  branch taken in EX; kill IF/ID contents
id_ex_memread  in  1  instruction currently in EX is a load
id_ex_register_rd  in  5  destination of instruction in EX
wb_regwrite  in  1  WB write enable
wb_rd  in  5  WB destination
wb_data  in  32  WB write data
stall  out  1  hold PC and IF; IF/ID latch also holds
if_id_register_rs1  out  5  instr[19:15]
if_id_register_rs2  out  5  instr[24:20]
if_id_register_rd  out  5  instr[11:7]
if_id_output_data_1  out  32  rs1 read data
if_id_output_data_2  out  32  rs2 read data
if_id_sign_extend_immediate  out  32  immediate
control  out  10  control word to ID/EX
illegal  out  1  latched instruction valid but opcode unsupported

Behaviour:
- Control word bits: [9] regwrite, [8] memtoreg, [7] memread, [6] memwrite, [5] branch, [4] alusrc, [3:0] alu_control.
- ALU codes: AND 0000, OR 0001, ADD 0010, SUB 0110.
- IF/ID latch (instr_q, valid_q): reset -> 0/0. Each edge: flush -> valid_q=0 (instr_q don't-care); else stall -> hold; else load if_instr/if_valid. Flush has priority over stall.
- Decode is combinational from instr_q; all outputs except register file are zero-latency from the latch.
- R-type 0110011: funct3 000 funct7[5]=0 ADD, =1 SUB; 111 AND; 110 OR; control = 10_0000_0 + alu. Other funct -> illegal.
- I-ALU 0010011: addi/andi/ori (funct3 000/111/110); regwrite=1, alusrc=1.
- Load 0000011 funct3 010: regwrite, memtoreg, memread, alusrc, ADD.
- Store 0100011 funct3 010: memwrite, alusrc, ADD; regwrite=0.
- Branch 1100011 funct3 000 (beq): branch=1, SUB, alusrc=0.
- Immediate: I = sext(instr[31:20]); S = sext({instr[31:25],instr[11:7]}); B = sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}); R-type = 0.
- control forced to 0 (bubble) when: valid_q=0, illegal, or stall. Index/data/imm outputs still reflect instr_q.
- illegal = valid_q & unsupported opcode/funct; never asserted when valid_q=0.
- Load-use hazard: stall = valid_q & id_ex_memread & (id_ex_register_rd != 0) & (rd_ex == rs1 | (rd_ex == rs2 & instruction uses rs2: R, store, branch)). Purely combinational, one-cycle per occurrence; EX sees bubble next cycle so stall self-clears.
- Register file: written on rising edge when wb_regwrite & wb_rd!=0. x0 reads 0 always. Bypass: if wb_regwrite & wb_rd!=0 & wb_rd==rsN, read data = wb_data same cycle.
- Reset: all registers 0, valid_q=0; outputs: control=0, stall=0, illegal=0, data=0, indices=0, imm=0. Reset mid-stall clears stall immediately (asynchronous).
- flush with stall simultaneously: latch invalidated, stall for current cycle still asserted combinationally; next cycle valid_q=0 so stall=0.

Test Plan:
- Reset asserted mid-run with valid_q=1 -> all outputs 0 asynchronously, x5 reads 0 after release.
- WB writes x3=0x0000_00AA, then ID holds add x4,x3,x3 (0x00318233) -> data1=data2=0xAA, control=0x202, imm=0.
- Same-cycle WB x7=0x1234 with ID sub x1,x7,x0 (0x400380B3) -> data1=0x1234 via bypass, data2=0, control=0x206.
- EX has load rd=x5 (memread=1), ID holds add x6,x5,x2 -> stall=1, control=0 one cycle, instr held; next cycle (memread=0) same instr issues control=0x202.
- sw x2,-4(x1) (0xFE20AE23) -> imm=0xFFFF_FFFC, control=0x052; beq with offset -8 (0xFE000CE3) -> imm=0xFFFF_FFF8, control=0x026.
- flush with valid instruction -> next cycle control=0, illegal=0; opcode 0x7F latched -> illegal=1, control=0.
